// File: rtl/sync_fifo_pkg.sv
// Shared constants and width helpers for the sync FIFO controller.
// ptr_w()      : pointer width (address bits plus one wrap bit).
// fifo_depth() : number of words addressable with a given address width.
// AFULL_MARGIN : default distance from full at which almost_full asserts.
package sync_fifo_pkg;

    localparam int unsigned AFULL_MARGIN = 4;

    function automatic int unsigned ptr_w(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

    function automatic int unsigned fifo_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/fifo_ptr_inc.sv
// Wrap-bit FIFO pointer register with increment and synchronous clear.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset, clears ptr
//   clr  : synchronous clear, takes priority over inc
//   inc  : advance the pointer by one (modulo 2**W)
//   ptr  : current pointer value, MSB is the wrap bit
module fifo_ptr_inc #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            // Natural modulo wrap; the MSB toggles every pass through the RAM.
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Pointer and flag controller turning a dual-port RAM with combinational
// read into a first-word-fall-through FIFO.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   flush        : synchronous clear of FIFO contents (blocks push/pop)
//   s_valid/ready: push handshake
//   m_valid/ready: pop handshake; head word is on the RAM output when m_valid
//   en_wr        : RAM write enable (high exactly on accepted pushes)
//   wr_addr      : RAM write address
//   r_addr       : RAM read address (head of FIFO)
//   count        : words stored, 0..2**ADDR_W
//   almost_full  : registered, count >= AFULL_LVL
//   overflow     : sticky dropped-push flag
// Optional feature: define SYNC_FIFO_OVF_FLAG_EN to enable the overflow flag;
// otherwise overflow is tied low.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned AFULL_LVL = fifo_depth(ADDR_W) - AFULL_MARGIN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              en_wr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] r_addr,
    output logic [ADDR_W:0]   count,
    output logic              almost_full,
    output logic              overflow
);

    localparam int unsigned PW = ptr_w(ADDR_W);

    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [ADDR_W:0] count_d;

    // Same slot but different lap means full; identical pointers mean empty.
    assign full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                   (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign empty = (wptr == rptr);

    assign s_ready = !full && !flush && !rst;
    assign m_valid = !empty && !flush;

    assign push  = s_valid && s_ready;
    assign pop   = m_valid && m_ready;
    assign en_wr = push;

    assign wr_addr = wptr[ADDR_W-1:0];
    assign r_addr  = rptr[ADDR_W-1:0];

    fifo_ptr_inc #(
        .W (PW)
    ) u_wptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (push),
        .ptr (wptr)
    );

    fifo_ptr_inc #(
        .W (PW)
    ) u_rptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (pop),
        .ptr (rptr)
    );

    always_comb begin
        count_d = count;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count + (ADDR_W + 1)'(1);
        end else if (pop && !push) begin
            count_d = count - (ADDR_W + 1)'(1);
        end
    end

    // almost_full tracks the next-state count so it moves on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            count       <= count_d;
            almost_full <= (count_d >= (ADDR_W + 1)'(AFULL_LVL));
        end
    end

`ifdef SYNC_FIFO_OVF_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (flush) begin
            overflow <= 1'b0;
        end else if (s_valid && full) begin
            overflow <= 1'b1;
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
module tb_sync_fifo_ctrl;

    localparam int unsigned AW    = 3;
    localparam int          DEPTH = 8;
    localparam int          AFL   = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          en_wr;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] r_addr;
    logic [AW:0]   count;
    logic          almost_full;
    logic          overflow;
    logic [7:0]    s_data = 8'h00;

    sync_fifo_ctrl #(
        .ADDR_W    (AW),
        .AFULL_LVL (AFL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .en_wr       (en_wr),
        .wr_addr     (wr_addr),
        .r_addr      (r_addr),
        .count       (count),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Stand-in for the dual-port RAM: synchronous write, combinational read.
    logic [7:0] ram [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) ram[i] = 8'h00;
    always @(posedge clk) if (en_wr) ram[wr_addr] <= s_data;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy, total pushes/pops mod depth, sticky flag.
    int        m_cnt = 0;
    int        m_wa  = 0;
    int        m_ra  = 0;
    bit        m_afull = 0;
    bit        m_ovf = 0;
    bit [7:0]  exp_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_wa = 0; m_ra = 0; m_afull = 0; m_ovf = 0;
            exp_q.delete();
        end else begin
            bit acc_push, acc_pop;
            acc_push = s_valid && !flush && (m_cnt < DEPTH);
            acc_pop  = m_ready && !flush && (m_cnt > 0);
`ifdef SYNC_FIFO_OVF_FLAG_EN
            if (flush) m_ovf = 0;
            else if (s_valid && m_cnt == DEPTH) m_ovf = 1;
`endif
            if (flush) begin
                m_cnt = 0; m_wa = 0; m_ra = 0;
                exp_q.delete();
            end else begin
                if (acc_push) begin
                    exp_q.push_back(s_data);
                    m_wa = (m_wa + 1) % DEPTH;
                end
                if (acc_pop) m_ra = (m_ra + 1) % DEPTH;
                m_cnt = m_cnt + int'(acc_push) - int'(acc_pop);
            end
            m_afull = (m_cnt >= AFL);
        end
    end

    // Monitor: status every cycle, data whenever the DUT presents a popped word.
    always @(negedge clk) begin
        chk("count", int'(count), m_cnt);
        chk("s_ready", int'(s_ready), int'(m_cnt < DEPTH && !flush && !rst));
        chk("m_valid", int'(m_valid), int'(m_cnt > 0 && !flush));
        chk("en_wr", int'(en_wr), int'(s_valid && m_cnt < DEPTH && !flush && !rst));
        chk("almost_full", int'(almost_full), int'(m_afull));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("wr_addr", int'(wr_addr), m_wa);
        chk("r_addr", int'(r_addr), m_ra);
        if (m_valid && m_ready) begin
            chk("pop_has_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("odata", int'(ram[r_addr]), int'(exp_q.pop_front()));
        end
    end

    task automatic cyc(input bit sv, input logic [7:0] d, input bit mr, input bit fl);
        s_valid = sv; s_data = d; m_ready = mr; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int budget = 40;
        while (m_cnt > 0 && budget > 0) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            budget--;
        end
        chk("drain_done", int'(m_cnt == 0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_count", int'(count), 0);
        rst = 1'b0;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill to full, one refused push, then drain in order
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        chk("full_count", int'(count), 8);
        cyc(1'b1, 8'h18, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        drain();

        // Simultaneous push+pop at full, then at count 4
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'h30, 1'b1, 1'b0);
        chk("full_pushpop_count", int'(count), 7);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 8'h31, 1'b1, 1'b0);
        chk("mid_pushpop_count", int'(count), 4);
        drain();

        // Asynchronous reset mid-stream with count 5
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        s_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_s_ready", int'(s_ready), 0);
        chk("async_rst_m_valid", int'(m_valid), 0);
        chk("async_rst_en_wr", int'(en_wr), 0);
        chk("async_rst_afull", int'(almost_full), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Random interleaved traffic across several pointer wraps
        for (int i = 0; i < 80; i++)
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        drain();

        // Flush with 3 stored words and a pending push (plus overflow clear)
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'h5f, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 8'h55, 1'b1, 1'b1);
        chk("flush_count", int'(count), 0);
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        cyc(1'b1, 8'hA6, 1'b0, 1'b0);
        drain();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Pointer and flag controller that turns the team's dual-port RAM into a first-word-fall-through FIFO for the Rx freq_correct path.
- Drives the RAM write enable, write address and read address.
- Exposes a valid/ready push port, a valid/ready pop port, an occupancy count and a programmable almost-full flag to the upstream sample source and the downstream corrector.
- RAM read is combinational, so the head word is presented on the RAM output whenever pop-side valid is high.

Parameters:
- ADDR_W, 10: RAM address width; FIFO depth = 2**ADDR_W.
- AFULL_LVL, 2**ADDR_W-4: almost_full asserts when count >= AFULL_LVL.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous clear of the FIFO contents
- s_valid  in  1  push request
- s_ready  out  1  push accepted when s_valid&&s_ready
- m_valid  out  1  head word valid on RAM odata
- m_ready  in  1  pop accepted when m_valid&&m_ready
- en_wr  out  1  RAM write enable
- wr_addr  out  ADDR_W  RAM write address
- r_addr  out  ADDR_W  RAM read address (head)
- count  out  ADDR_W+1  words stored, 0..2**ADDR_W
- almost_full  out  1  count >= AFULL_LVL
- overflow  out  1  sticky overflow error (feature only)

Behaviour:
- **Pointers:** wptr and rptr are ADDR_W+1 bits; the MSB is the wrap bit. wr_addr = wptr[ADDR_W-1:0], r_addr = rptr[ADDR_W-1:0].
- **Reset:** wptr=0, rptr=0, count=0, overflow=0.
  - While rst is high: s_ready=0, m_valid=0, en_wr=0, almost_full=0.
- **Status decode:**
  - full = (wptr[ADDR_W]!=rptr[ADDR_W]) && low bits equal.
  - empty = (wptr==rptr).
  - s_ready = !full && !flush && !rst.
  - m_valid = !empty && !flush.
- **Push:** when s_valid&&s_ready, en_wr=1 combinationally in the same cycle and wptr increments at the clock edge. en_wr is never high otherwise.
- **Pop:** when m_valid&&m_ready, rptr increments at the clock edge.
- **Count:** registered. +1 on push only, -1 on pop only, unchanged on both or neither.
- **Latency:**
  - First write into an empty FIFO: m_valid rises in the cycle after the accepting edge.
  - Pop to next head word: visible in the following cycle.
- **Full with simultaneous pop:** s_ready=0, push refused; the pop proceeds, and s_ready=1 on the next cycle.
- **Empty with s_valid:** push accepted, m_valid stays 0 that cycle. No bypass path.
- **Wrap-around:** pointer increments are modulo 2**(ADDR_W+1), with no special case at 2**ADDR_W-1 -> 0.
- **Flush:** highest priority after rst. Pointers and count clear to 0 at the edge, and no push or pop is accepted in the flush cycle.
- **almost_full:** registered, derived from the next-state count; updates on the same edge as count.
- **Reset mid-operation:** all state clears immediately. Stored RAM data is not cleared, and becomes unreachable.
- No FSM; the state is the two pointers plus count.

Optional Feature:
- Macro: SYNC_FIFO_OVF_FLAG_EN.
- Defined: overflow is set at an edge where s_valid=1 and full=1 (dropped push). It is sticky, cleared only by rst or flush.
- Undefined: overflow is tied to 0. The port is kept for a stable interface.

Decomposition:
- Package sync_fifo_pkg: ptr_t width helper (ADDR_W+1), FIFO_DEPTH function of ADDR_W, default AFULL margin constant 4.
- One natural sub-module: fifo_ptr_inc (wrap-bit pointer register with increment and clear), instantiated twice for the write and read pointers.
- Top level: the existing RAM plus sync_fifo_ctrl, wired in a thin freq_correct-level wrapper.

Test Plan (ADDR_W=3, depth 8, AFULL_LVL=6):
- **Reset check:** rst pulse mid-stream with count=5 -> all outputs return to 0 asynchronously; after release s_ready=1, m_valid=0, count=0.
- **Fill to full:** 8 pushes of 0x10..0x17 with m_ready=0 -> count=8, s_ready=0, almost_full=1 from count 6; 9th push refused and en_wr stays 0; overflow=1 with the macro, 0 without.
- **Drain in order:** then drain with m_ready=1 -> odata sequence 0x10..0x17, m_valid low after the 8th pop, count=0.
- **Simultaneous at full:** push+pop at count=8 -> count=7, no write; at count=4 -> count stays 4, wr_addr and r_addr both advance.
- **Wrap-around:** 20 interleaved push/pop words with random stalls -> output order equals input order, pointer low bits wrap 7->0 without glitching m_valid.
- **Flush:** flush with count=3 and s_valid=1 -> no write that cycle, count=0 next cycle, overflow cleared, next pushed word appears first on odata.
